pcileech_wake_ctrl: RTL
=======================

PCILEECH_WAKE_CTRL -- requirements
Module: pcileech_wake_ctrl

Interface
REQ-001 Parameter PARAM_WAKE_TIMEOUT, default 32'd100_000_000, is the maximum number of cycles one WAKE# assertion may last (1 s at 100 MHz).
REQ-002 Parameter PARAM_RETRY_GAP, default 32'd1_000_000, is the number of deasserted cycles between assertion attempts.
REQ-003 Parameter PARAM_MAX_RETRY, default 4'd3, is the number of retries after the first attempt.
REQ-004 Port list:
- clk  in  1  system clock; the single clock.
- rst  in  1  synchronous, active-high reset.
- wake_en  in  1  PME/wake permitted (software enable).
- wake_req  in  1  single-cycle wake request.
- pcie_perst_n  in  1  asynchronous PERST#.
- pcie_lnk_up  in  1  link-up status, already in the clk domain.
- pcie_wake_n  out  1  WAKE#, registered, active low.
- wake_busy  out  1  high in any state other than IDLE.
- wake_done  out  1  one-cycle pulse: link is up after wake.
- wake_fail  out  1  one-cycle pulse: retries exhausted.
- wake_cnt  out  8  count of WAKE# assertions.

Function
REQ-005 pcie_perst_n SHALL pass through a 2-flop synchronizer (perst_s) before use; perst_s rising edge = a registered perst_s low in the previous cycle, high now.
REQ-006 FSM states SHALL be IDLE, ASSERT, RELEASE, GAP; the 32-bit timer clears on every state entry.
REQ-007 IDLE: pcie_wake_n=1. The block SHALL leave IDLE only when wake_req=1, wake_en=1 and pcie_lnk_up=0, moving to ASSERT with retry=0.
REQ-008 In IDLE, wake_req with pcie_lnk_up=1 or wake_en=0 SHALL be ignored (no pulse); in any other state wake_req SHALL be ignored (no queueing).
REQ-009 ASSERT: pcie_wake_n=0 starting the cycle after the accepting edge (latency 1).
REQ-010 ASSERT transitions, in priority order:
- pcie_lnk_up=1 -> IDLE with wake_done.
- perst_s rising edge -> RELEASE.
- timer==PARAM_WAKE_TIMEOUT-1 -> GAP if retry<PARAM_MAX_RETRY, else IDLE with wake_fail.
REQ-011 RELEASE: pcie_wake_n=1. Transitions:
- pcie_lnk_up=1 -> IDLE with wake_done.
- timer==PARAM_WAKE_TIMEOUT-1 -> same retry rule as ASSERT.
REQ-012 GAP: pcie_wake_n=1. At timer==PARAM_RETRY_GAP-1 -> ASSERT with retry+1. pcie_lnk_up=1 during GAP -> IDLE with wake_done.
REQ-013 wake_en=0 in any non-IDLE state SHALL abort to IDLE the next cycle with pcie_wake_n=1 and no pulse; the abort has priority over all other transitions.
REQ-014 wake_done and wake_fail SHALL be registered, mutually exclusive, and asserted for exactly the cycle in which the FSM enters IDLE.
REQ-015 The timer SHALL be 32-bit unsigned with no wrap; the timeout comparison stops it.
REQ-016 retry SHALL be 4-bit and never exceed PARAM_MAX_RETRY; PARAM_MAX_RETRY=0 gives exactly one attempt.

Reset
REQ-017 On rst=1 at a clk edge the block SHALL set:
- state IDLE, pcie_wake_n=1, wake_busy=0, wake_done=0, wake_fail=0, wake_cnt=0, timer=0, retry=0.
- synchronizer flops to 1 (PERST# inactive).
REQ-018 rst asserted mid-operation SHALL release WAKE# on the next edge and produce no pulse.

Configuration
REQ-019 Macro PCILEECH_WAKE_STATUS_EN:
- Defined: wake_cnt increments, saturating at 8'hFF, on every entry into ASSERT, including retries.
- Undefined: wake_cnt is constant 8'h00 and no counter register is synthesized.
- All other behaviour is identical either way.

Verification
Bench parameters: PARAM_WAKE_TIMEOUT=16, PARAM_RETRY_GAP=4, PARAM_MAX_RETRY=2.
REQ-020 wake_en=1, lnk_up=0, wake_req at cycle 10, lnk_up=1 at cycle 15:
- wake_n low in cycles 11..15, high at 16.
- wake_done pulse at 16.
- wake_cnt=1.
REQ-021 Link never rises:
- Three 16-cycle lows separated by 4-cycle highs.
- wake_fail pulse one cycle after the third low ends.
- wake_cnt=3 with macro defined, 0 without.
REQ-022 After acceptance, PERST# deasserted at cycle 5:
- wake_n high 3 cycles later (2-flop sync plus edge detect).
- lnk_up at cycle 12 -> wake_done.
REQ-023 wake_en dropped at cycle 6 of ASSERT:
- wake_n high next cycle.
- FSM in IDLE, no pulses.
- A second wake_req while busy is ignored.
REQ-024 Boundary cases:
- wake_req with lnk_up=1 -> no activity.
- rst at cycle 3 of GAP -> all outputs at reset values; wake_cnt=0.

Source files
------------

// File: rtl/pcileech_wake_ctrl.sv
// PCIe WAKE# sequencer: asserts WAKE# until link-up, with timed retries and PERST# release.
// Optional assertion counter on wake_cnt enabled by macro PCILEECH_WAKE_STATUS_EN.
//
// state   | meaning
// IDLE    | WAKE# released, waiting for an accepted wake_req
// ASSERT  | WAKE# driven low, waiting for link-up / PERST# release / timeout
// RELEASE | host released PERST#; WAKE# released, waiting for link-up
// GAP     | WAKE# released between attempts
module pcileech_wake_ctrl #(
  parameter logic [31:0] PARAM_WAKE_TIMEOUT = 32'd100_000_000,
  parameter logic [31:0] PARAM_RETRY_GAP    = 32'd1_000_000,
  parameter logic [3:0]  PARAM_MAX_RETRY    = 4'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wake_en,
  input  logic       wake_req,
  input  logic       pcie_perst_n,
  input  logic       pcie_lnk_up,
  output logic       pcie_wake_n,
  output logic       wake_busy,
  output logic       wake_done,
  output logic       wake_fail,
  output logic [7:0] wake_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2,
    GAP     = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [3:0]  retry_q, retry_d;
  logic        wake_n_q, wake_n_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;
  logic        perst_s1_q, perst_s_q, perst_prev_q;
  logic        perst_rise;
  logic        wake_tmo, gap_end;

  assign perst_rise = perst_s_q & ~perst_prev_q;
  assign wake_tmo   = (timer_q == PARAM_WAKE_TIMEOUT - 32'd1);
  assign gap_end    = (timer_q == PARAM_RETRY_GAP - 32'd1);

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wake_req && wake_en && !pcie_lnk_up) begin
          state_d = ASSERT;
          retry_d = 4'd0;
        end
      end
      ASSERT: begin
        if (!wake_en) begin
          state_d = IDLE;
        end else if (pcie_lnk_up) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (perst_rise) begin
          state_d = RELEASE;
        end else if (wake_tmo) begin
          if (retry_q < PARAM_MAX_RETRY) begin
            state_d = GAP;
          end else begin
            state_d = IDLE;
            fail_d  = 1'b1;
          end
        end
      end
      RELEASE: begin
        if (!wake_en) begin
          state_d = IDLE;
        end else if (pcie_lnk_up) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (wake_tmo) begin
          if (retry_q < PARAM_MAX_RETRY) begin
            state_d = GAP;
          end else begin
            state_d = IDLE;
            fail_d  = 1'b1;
          end
        end
      end
      GAP: begin
        if (!wake_en) begin
          state_d = IDLE;
        end else if (pcie_lnk_up) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (gap_end) begin
          state_d = ASSERT;
          retry_d = retry_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Timer restarts on each state entry and saturates rather than wrapping.
  always_comb begin
    timer_d = timer_q;
    if ((state_d != state_q) || (state_q == IDLE)) begin
      timer_d = 32'd0;
    end else if (timer_q != 32'hFFFF_FFFF) begin
      timer_d = timer_q + 32'd1;
    end
  end

  assign wake_n_d = (state_d != ASSERT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= 32'd0;
      retry_q      <= 4'd0;
      wake_n_q     <= 1'b1;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      perst_s1_q   <= 1'b1;
      perst_s_q    <= 1'b1;
      perst_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      wake_n_q     <= wake_n_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      perst_s1_q   <= pcie_perst_n;
      perst_s_q    <= perst_s1_q;
      perst_prev_q <= perst_s_q;
    end
  end

`ifdef PCILEECH_WAKE_STATUS_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'h00;
    end else if ((state_d == ASSERT) && (state_q != ASSERT) && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'h01;
    end
  end

  assign wake_cnt = cnt_q;
`else
  assign wake_cnt = 8'h00;
`endif

  assign pcie_wake_n = wake_n_q;
  assign wake_busy   = (state_q != IDLE);
  assign wake_done   = done_q;
  assign wake_fail   = fail_q;

endmodule
